// File: rtl/ef_i2s_tx.sv
// I2S master transmitter: prescaled SCK/WS generation, 2**AW x 32 sample FIFO, MSB-first serialiser.
// Latency: a sample loads into the shifter on the slot-start SCK fall. The MSB appears on sdo at that edge (left-justified) or one SCK later (I2S).
// Backpressure: writes while full are dropped, except in a cycle that also pops. An empty FIFO at an enabled slot start sets sticky underflow.
//
// Ports: clk/rst_n (synchronous, active-low); sck/ws/sdo codec pins;
//        fifo_wr/fifo_wdata push side; fifo_full/fifo_empty/fifo_level/fifo_level_below status;
//        fifo_level_threshold compare value; underflow/underflow_clr sticky error;
//        left_justified, sample_size, sck_prescaler, channels, en live controls.
// Optional: define EF_I2S_TX_HOLD_LAST_EN to repeat each channel's last sample on underflow.
module ef_i2s_tx #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          sck,
    output logic          ws,
    output logic          sdo,
    input  logic          fifo_wr,
    input  logic [31:0]   fifo_wdata,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    input  logic [AW:0]   fifo_level_threshold,
    output logic          fifo_level_below,
    output logic          underflow,
    input  logic          underflow_clr,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [7:0]    sck_prescaler,
    input  logic [1:0]    channels,
    input  logic          en
);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    presc;
    logic [4:0]    bit_ctr;
    logic [31:0]   sr;
    logic          sdo_dly;

    logic          fall_tick;
    logic          slot_start;
    logic          ch_en;
    logic          pop;
    logic          push;
    logic          starve;
    logic [4:0]    size_m1;
    logic [4:0]    shamt;
    logic [31:0]   rdata_al;
    logic [31:0]   slot_data;

    assign fifo_full        = (fifo_level == (AW+1)'(DEPTH));
    assign fifo_empty       = (fifo_level == '0);
    assign fifo_level_below = (fifo_level < fifo_level_threshold);

    // A slot start toggles ws, so the slot's channel is the inverse of the current ws.
    assign fall_tick  = en && (presc == 8'd0) && sck;
    assign slot_start = fall_tick && (bit_ctr == 5'd31);
    assign ch_en      = ws ? channels[1] : channels[0];
    assign pop        = slot_start && ch_en && !fifo_empty;
    assign starve     = slot_start && ch_en && fifo_empty;
    // A pop frees a slot in the same cycle, so a write is accepted even when full.
    assign push       = fifo_wr && (!fifo_full || pop);

    // The left-shift amount 32-size equals ~(size-1) in 5 bits.
    assign size_m1  = ((sample_size == 6'd0) || (sample_size > 6'd32)) ? 5'd31 : 5'(sample_size - 6'd1);
    assign shamt    = ~size_m1;
    assign rdata_al = mem[rd_ptr] << shamt;

    assign sdo = left_justified ? sr[31] : sdo_dly;

`ifdef EF_I2S_TX_HOLD_LAST_EN
    logic [31:0] last_l;
    logic [31:0] last_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (pop) begin
            if (ws) last_l <= rdata_al;
            else    last_r <= rdata_al;
        end
    end

    always_comb begin
        slot_data = '0;
        if (pop)         slot_data = rdata_al;
        else if (starve) slot_data = ws ? last_l : last_r;
    end
`else
    always_comb begin
        slot_data = '0;
        if (pop) slot_data = rdata_al;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Serialiser and clock generation; en=0 holds the same idle state as reset.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            presc   <= 8'd0;
            sck     <= 1'b0;
            ws      <= 1'b1;
            bit_ctr <= 5'd31;
            sr      <= '0;
            sdo_dly <= 1'b0;
        end else begin
            if (presc == 8'd0) begin
                presc <= sck_prescaler;
                sck   <= ~sck;
            end else begin
                presc <= presc - 8'd1;
            end
            if (fall_tick) begin
                bit_ctr <= bit_ctr + 5'd1;
                sdo_dly <= sr[31];
                if (slot_start) begin
                    ws <= ~ws;
                    sr <= slot_data;
                end else begin
                    sr <= {sr[30:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)             underflow <= 1'b0;
        else if (underflow_clr) underflow <= 1'b0;
        else if (starve)        underflow <= 1'b1;
    end
endmodule
